stage5_field_extract: RTL and testbench
=======================================

# stage5_field_extract

Parametrised, registered successor to the stage-5 per-channel field extractors. It pulls one fixed bit-field out of each of NUM_CH message channels and gates each channel by the message enable and its mux control. The result is presented through a valid/ready output register. Optionally, an inactive channel re-issues its last valid field instead of the default value. Per-channel saturating activity counters are included for stage-5 statistics. The block sits between the stage-4 message mux and the stage-5 field consumers.

## Interface
- NUM_CH, 3, number of message channels
- MSG_BITS, 128, width of one message
- FIELD_LSB, 0, bit offset of the field inside a message
- FIELD_BITS, 16, field width; FIELD_LSB+FIELD_BITS <= MSG_BITS (elaboration error otherwise)
- CTRL_W, 3, width of one mux-control word
- MUX_DEFAULT, 0, mux-control value meaning "channel unused"
- DEFAULT_INFO, 0, field value driven for an inactive channel
- CNT_W, 16, activity counter width
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- hold_mode  in  1  1: an inactive channel outputs its last active field; 0: it outputs DEFAULT_INFO
- clr_stats  in  1  synchronous clear of all activity counters
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- message_en  in  1  global message enable
- message  in  NUM_CH*MSG_BITS  channel c = message[c*MSG_BITS +: MSG_BITS]
- mux_ctrl  in  NUM_CH*CTRL_W  channel c = mux_ctrl[c*CTRL_W +: CTRL_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- field  out  NUM_CH*FIELD_BITS  extracted field per channel
- field_act  out  NUM_CH  channel-active flag per channel
- act_cnt  out  NUM_CH*CNT_W  per-channel count of accepted active beats

## Operation
- Channel active: act[c] = message_en && (mux_ctrl[c] != MUX_DEFAULT).
- Extracted value: ext[c] = message[c*MSG_BITS+FIELD_LSB +: FIELD_BITS].
- Accept: acc = in_valid && in_ready. Ready rule: in_ready = rst_n && (!out_valid || out_ready).
- On acc, out_valid <= 1. For every channel c:
  - field_act[c] <= act[c].
  - field[c] <= act[c] ? ext[c] : (hold_mode ? last[c] : DEFAULT_INFO).
  - If act[c], then last[c] <= ext[c]. last[c] updates regardless of hold_mode.
- On !acc && out_ready, out_valid <= 0. field and field_act keep their values.
- While out_valid && !out_ready, field and field_act are held stable.
- Counters:
  - On acc && act[c], act_cnt[c] increments, saturating at 2^CNT_W-1.
  - clr_stats sets all counters to 0.
  - clr_stats together with acc && act[c]: act_cnt[c] = 1. Clear is applied first, then the count.
- hold_mode is sampled only on the accept cycle. last[c] is used exactly as stored before this beat.
- message_en=0: all channels inactive, no counter moves, and all last[c] stay unchanged.

## Timing
- Latency: 1 cycle from acc to out_valid=1 with the corresponding field.
- Throughput: 1 beat/cycle when out_ready is held high. in_ready is combinational from out_valid and out_ready only.
- No combinational path from in_valid or message to any output.
- Reset (rst_n low, asynchronous) values:
  - out_valid=0, in_ready=0
  - field = DEFAULT_INFO in every channel, field_act=0
  - all last[c]=DEFAULT_INFO, all act_cnt=0
- Reset mid-operation: a beat pending at the output is dropped with no handshake. The first beat after rst_n rises is accepted the cycle in_valid is seen.
- Counter saturation: at 2^CNT_W-1 the counter holds. It does not wrap.

## Test plan
- Reset: assert rst_n low mid-stream -> outputs immediately at reset values; after release, in_ready=1 on the next cycle.
- Basic extraction (defaults), message_en=1, mux_ctrl={1,2,3}:
  - message channel fields = 16'hA001, 16'hB002, 16'hC003.
  - Required: one cycle later out_valid=1, field={C003,B002,A001}, field_act=3'b111, act_cnt={1,1,1}.
- Default vs hold:
  - Beat1 has channel 1 active with field 16'h1234.
  - Beat2 has mux_ctrl[1]=0 with hold_mode=0 -> field[1]=0; Beat3 has mux_ctrl[1]=0 with hold_mode=1 -> field[1]=16'h1234.
  - field_act[1]=0 on beats 2 and 3.
- Backpressure:
  - out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, field stable, act_cnt unchanged.
  - Raise out_ready -> one beat per cycle resumes, with no beat lost or duplicated.
- Counters (CNT_W=2):
  - 5 active beats on channel 0 -> act_cnt[0] saturates at 3.
  - clr_stats with an active accept -> act_cnt[0]=1; clr_stats alone -> 0.
- Global disable: message_en=0 with all mux_ctrl nonzero -> field=DEFAULT_INFO everywhere (hold_mode=0), field_act=0, counters unchanged.

Source files
------------

// File: rtl/stage5_field_extract.sv
// Stage-5 per-channel field extractor: one fixed bit-field per message channel,
// gated by message enable and mux control, behind a valid/ready output register.
module stage5_field_extract #(
    parameter int                    NUM_CH       = 3,
    parameter int                    MSG_BITS     = 128,
    parameter int                    FIELD_LSB    = 0,
    parameter int                    FIELD_BITS   = 16,
    parameter int                    CTRL_W       = 3,
    parameter logic [CTRL_W-1:0]     MUX_DEFAULT  = '0,
    parameter logic [FIELD_BITS-1:0] DEFAULT_INFO = '0,
    parameter int                    CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hold_mode,
    input  logic                         clr_stats,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         message_en,
    input  logic [NUM_CH*MSG_BITS-1:0]   message,
    input  logic [NUM_CH*CTRL_W-1:0]     mux_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*FIELD_BITS-1:0] field,
    output logic [NUM_CH-1:0]            field_act,
    output logic [NUM_CH*CNT_W-1:0]      act_cnt
);

    if (FIELD_LSB + FIELD_BITS > MSG_BITS) begin : g_bad_field
        $error("stage5_field_extract: field does not fit inside one message");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic acc;
    logic out_valid_q;
    logic unused_msg;

    assign in_ready  = rst_n && (!out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;
    assign out_valid = out_valid_q;

    // Message bits outside the extracted field are intentionally ignored.
    assign unused_msg = ^message;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (acc) begin
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                  act_c;
        logic [FIELD_BITS-1:0] ext_c;
        logic [FIELD_BITS-1:0] last_q;
        logic [FIELD_BITS-1:0] field_q;
        logic                  field_act_q;
        logic [CNT_W-1:0]      cnt_q;

        assign act_c = message_en && (mux_ctrl[c*CTRL_W +: CTRL_W] != MUX_DEFAULT);
        assign ext_c = message[c*MSG_BITS+FIELD_LSB +: FIELD_BITS];

        // Inactive channels read last_q before this beat can overwrite it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                field_q     <= DEFAULT_INFO;
                field_act_q <= 1'b0;
                last_q      <= DEFAULT_INFO;
            end else if (acc) begin
                field_act_q <= act_c;
                if (act_c) begin
                    field_q <= ext_c;
                    last_q  <= ext_c;
                end else begin
                    field_q <= hold_mode ? last_q : DEFAULT_INFO;
                end
            end
        end

        // Clear wins first, then the same-cycle active accept counts as one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr_stats) begin
                cnt_q <= (acc && act_c) ? CNT_W'(1) : '0;
            end else if (acc && act_c && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign field[c*FIELD_BITS +: FIELD_BITS] = field_q;
        assign field_act[c]                      = field_act_q;
        assign act_cnt[c*CNT_W +: CNT_W]         = cnt_q;
    end

endmodule

// File: tb/tb_stage5_field_extract.sv
// Randomized and directed bench for stage5_field_extract against a
// beat-level reference model (CNT_W=2 so saturation is reachable).
module tb_stage5_field_extract;

    localparam int NUM_CH   = 3;
    localparam int MSG_BITS = 128;
    localparam int FB       = 16;
    localparam int CW       = 3;
    localparam int CNT_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     hold_mode = 1'b0;
    logic                     clr_stats = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     message_en = 1'b0;
    logic [NUM_CH*MSG_BITS-1:0] message = '0;
    logic [NUM_CH*CW-1:0]     mux_ctrl = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [NUM_CH*FB-1:0]     field;
    logic [NUM_CH-1:0]        field_act;
    logic [NUM_CH*CNT_W-1:0]  act_cnt;

    always #5 clk = ~clk;

    stage5_field_extract #(
        .NUM_CH(NUM_CH), .MSG_BITS(MSG_BITS), .FIELD_LSB(0), .FIELD_BITS(FB),
        .CTRL_W(CW), .MUX_DEFAULT('0), .DEFAULT_INFO('0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold_mode(hold_mode), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .message_en(message_en),
        .message(message), .mux_ctrl(mux_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .field(field), .field_act(field_act), .act_cnt(act_cnt)
    );

    int total = 0;
    int bad   = 0;

    // reference model state, one entry per channel
    logic [FB-1:0] m_last  [NUM_CH];
    logic [FB-1:0] m_field [NUM_CH];
    logic          m_act   [NUM_CH];
    int            m_cnt   [NUM_CH];
    logic          m_valid;
    // stimulus as the model sees it
    logic [FB-1:0] s_ext   [NUM_CH];
    int            s_mux   [NUM_CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_field();
        logic [63:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*FB +: FB] = m_field[c];
        return v;
    endfunction

    function automatic logic [63:0] exp_act();
        logic [63:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_act[c];
        return v;
    endfunction

    function automatic logic [63:0] exp_cnt();
        logic [63:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*CNT_W +: CNT_W] = m_cnt[c][CNT_W-1:0];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_last[c] = '0; m_field[c] = '0; m_act[c] = 1'b0; m_cnt[c] = 0;
        end
        m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".field"},     64'(field),     exp_field());
        check({tag, ".field_act"}, 64'(field_act), exp_act());
        check({tag, ".act_cnt"},   64'(act_cnt),   exp_cnt());
    endtask

    task automatic set_beat(input logic vld, input logic en, input logic hold,
                            input int mux0, input int mux1, input int mux2,
                            input logic [FB-1:0] f0, input logic [FB-1:0] f1,
                            input logic [FB-1:0] f2);
        logic [MSG_BITS-1:0] m;
        s_mux[0] = mux0; s_mux[1] = mux1; s_mux[2] = mux2;
        s_ext[0] = f0;   s_ext[1] = f1;   s_ext[2] = f2;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < MSG_BITS/32; w++) m[w*32 +: 32] = $urandom;
            m[FB-1:0] = s_ext[c];
            message[c*MSG_BITS +: MSG_BITS] = m;
            mux_ctrl[c*CW +: CW] = CW'(s_mux[c]);
        end
        in_valid = vld; message_en = en; hold_mode = hold;
    endtask

    // One clock: check in_ready, clock, advance the model, compare outputs.
    task automatic cycle(input string tag);
        logic acc;
        logic a;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || out_ready));
        acc = in_valid && (!m_valid || out_ready);
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            a = message_en && (s_mux[c] != 0);
            if (clr_stats) m_cnt[c] = 0;
            if (acc && a && m_cnt[c] < (1 << CNT_W) - 1) m_cnt[c]++;
            if (acc) begin
                m_act[c]   = a;
                m_field[c] = a ? s_ext[c] : (hold_mode ? m_last[c] : '0);
                if (a) m_last[c] = s_ext[c];
            end
        end
        if (acc) m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, ".in_ready"},  64'(in_ready),  64'd0);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".field"},     64'(field),     64'd0);
        check({tag, ".field_act"}, 64'(field_act), 64'd0);
        check({tag, ".act_cnt"},   64'(act_cnt),   64'd0);
    endtask

    logic [NUM_CH*FB-1:0] held_field;

    initial begin
        model_reset();
        set_beat(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_now("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle("post_reset");

        // basic extraction
        set_beat(1, 1, 0, 1, 2, 3, 16'hA001, 16'hB002, 16'hC003);
        cycle("basic");
        check("basic.field_const", 64'(field), 64'h0000_C003_B002_A001);
        check("basic.act_const", 64'(field_act), 64'b111);
        check("basic.cnt_const", 64'(act_cnt), 64'b01_01_01);

        // default vs hold on channel 1
        set_beat(1, 1, 0, 1, 1, 1, 16'h1111, 16'h1234, 16'h3333);
        cycle("hold.beat1");
        set_beat(1, 1, 0, 1, 0, 1, 16'h2222, 16'h5555, 16'h4444);
        cycle("hold.beat2");
        check("hold.beat2_f1", 64'(field[31:16]), 64'h0);
        check("hold.beat2_act1", 64'(field_act[1]), 64'd0);
        set_beat(1, 1, 1, 1, 0, 1, 16'h6666, 16'h7777, 16'h8888);
        cycle("hold.beat3");
        check("hold.beat3_f1", 64'(field[31:16]), 64'h1234);
        check("hold.beat3_act1", 64'(field_act[1]), 64'd0);

        // backpressure: output is valid, downstream stalls for 4 cycles
        held_field = field;
        out_ready = 1'b0;
        set_beat(1, 1, 0, 2, 2, 2, 16'h0A0A, 16'h0B0B, 16'h0C0C);
        for (int i = 0; i < 4; i++) cycle("bp.stall");
        check("bp.field_stable", 64'(field), 64'(held_field));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_beat(1, 1, 0, 1, 3, 5, FB'(16'h100 + i), FB'(16'h200 + i), FB'(16'h300 + i));
            cycle("bp.resume");
        end

        // counter saturation and clear
        set_beat(0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        clr_stats = 1'b1;
        cycle("cnt.clear0");
        clr_stats = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_beat(1, 1, 0, 4, 0, 0, FB'(16'h5000 + i), 16'h0, 16'h0);
            cycle("cnt.sat");
        end
        check("cnt.sat_const", 64'(act_cnt[1:0]), 64'd3);
        clr_stats = 1'b1;
        set_beat(1, 1, 0, 4, 0, 0, 16'h5A5A, 16'h0, 16'h0);
        cycle("cnt.clr_acc");
        check("cnt.clr_acc_const", 64'(act_cnt[1:0]), 64'd1);
        set_beat(0, 1, 0, 4, 0, 0, 16'h5A5A, 16'h0, 16'h0);
        cycle("cnt.clr_only");
        check("cnt.clr_only_const", 64'(act_cnt[1:0]), 64'd0);
        clr_stats = 1'b0;

        // global disable
        set_beat(1, 1, 0, 1, 1, 1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        cycle("dis.prime");
        set_beat(1, 0, 0, 1, 2, 3, 16'hDDDD, 16'hEEEE, 16'hFFFF);
        cycle("dis.beat");
        check("dis.field_const", 64'(field), 64'h0);
        check("dis.act_const", 64'(field_act), 64'h0);
        set_beat(1, 1, 1, 0, 0, 0, 16'h1, 16'h2, 16'h3);
        cycle("dis.last_kept");
        check("dis.last_const", 64'(field), 64'h0000_CCCC_BBBB_AAAA);

        // randomized traffic with one asynchronous reset mid-stream
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(3) != 0);
            clr_stats = ($urandom_range(19) == 0);
            set_beat(($urandom_range(3) != 0), ($urandom_range(7) != 0), 1'($urandom),
                     ($urandom_range(2) == 0) ? 0 : int'($urandom_range(7)),
                     ($urandom_range(2) == 0) ? 0 : int'($urandom_range(7)),
                     ($urandom_range(2) == 0) ? 0 : int'($urandom_range(7)),
                     FB'($urandom), FB'($urandom), FB'($urandom));
            cycle("rand");
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1;
                check_reset_now("midreset");
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
                out_ready = 1'b0;
                set_beat(1, 1, 0, 1, 1, 1, 16'h7A7A, 16'h7B7B, 16'h7C7C);
                cycle("midreset.first");
                check("midreset.first_valid", 64'(out_valid), 64'd1);
            end
        end

        clr_stats = 1'b0;
        in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
